// File: rtl/cpu_pkg.sv
// Shared CPU package: completion-bus packet format and register-file
// constants used by the multiplier completion buffer.
//   ROB_IDX_W  - reorder-buffer index width
//   PRF_IDX_W  - physical register tag width
//   ZERO_REG   - tag of the hardwired zero register
//   cdb_pkt_t  - one common-data-bus broadcast {result, rob_idx, dest_tag}
package cpu_pkg;

  localparam int ROB_IDX_W = 5;
  localparam int PRF_IDX_W = 6;

  localparam logic [PRF_IDX_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [63:0]          result;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [PRF_IDX_W-1:0] dest_tag;
  } cdb_pkt_t;

endpackage

// File: rtl/cdb_fifo.sv
// Circular FIFO of cdb_pkt_t entries with wrap-around head/tail pointers.
// Ports:
//   clock, reset  - clock and synchronous active-high reset
//   clear         - drop every entry (head jumps to tail); overrides push/pop
//   push, push_data - write push_data at tail (ignored when full without pop)
//   pop           - advance head (ignored when empty)
//   head_data     - oldest entry, all zeros when empty
//   count         - occupied entries (0..DEPTH)
//   full, empty   - occupancy flags
module cdb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  cdb_pkt_t               push_data,
  input  logic                   pop,
  output cdb_pkt_t               head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  cdb_pkt_t         mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign pop_ok  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push at full is accepted.
  assign push_ok = push & (~full | pop_ok);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    head_data = '0;
    if (!empty) head_data = mem[head];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear) begin
      head  <= tail;
      count <= '0;
    end else begin
      if (push_ok) tail <= next_ptr(tail);
      if (pop_ok)  head <= next_ptr(head);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // NOTE: storage is not reset; validity is tracked by count and the head
  // output is masked when empty, so the array maps onto plain RAM.
  always_ff @(posedge clock) begin
    if (!reset && !clear && push_ok) mem[tail] <= push_data;
  end

endmodule

// File: rtl/mult_cdb_buffer.sv
// Completion buffer behind the 4-stage pipelined multiplier. Captures every
// product with its ROB index and destination tag, queues it for the common
// data bus, and returns credit so an accepted start never overflows it.
// Ports:
//   clock, reset     - clock and synchronous active-high reset
//   flush_i          - squash all queued and in-flight results
//   mult_start_i     - an op enters the multiplier this cycle
//   mult_done_i      - multiplier result valid this cycle
//   mult_product_i, mult_rob_idx_i, mult_dest_tag_i - result payload
//   issue_ready_o    - a start may be accepted this cycle
//   cdb_req_o, cdb_gnt_i - broadcast handshake with the CDB arbiter
//   cdb_result_o, cdb_rob_idx_o, cdb_dest_tag_o - head entry (0 when empty)
//   count_o          - occupied entries
module mult_cdb_buffer
  import cpu_pkg::cdb_pkt_t;
#(
  parameter int DEPTH     = 4,
  parameter int LAT       = 4,
  parameter int ROB_IDX_W = cpu_pkg::ROB_IDX_W,
  parameter int PRF_IDX_W = cpu_pkg::PRF_IDX_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush_i,
  input  logic                   mult_start_i,
  input  logic                   mult_done_i,
  input  logic [63:0]            mult_product_i,
  input  logic [ROB_IDX_W-1:0]   mult_rob_idx_i,
  input  logic [PRF_IDX_W-1:0]   mult_dest_tag_i,
  output logic                   issue_ready_o,
  output logic                   cdb_req_o,
  input  logic                   cdb_gnt_i,
  output logic [63:0]            cdb_result_o,
  output logic [ROB_IDX_W-1:0]   cdb_rob_idx_o,
  output logic [PRF_IDX_W-1:0]   cdb_dest_tag_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int IF_W = $clog2(LAT + 1);

  logic [IF_W-1:0] inflight;
  logic [IF_W-1:0] inflight_next;
  logic [IF_W-1:0] squash;
  logic            push;
  logic            pop;
  logic            discard;
  logic            fifo_full;
  logic            fifo_empty;
  cdb_pkt_t        push_pkt;
  cdb_pkt_t        head_pkt;

  always_comb begin
    inflight_next = inflight + IF_W'(mult_start_i) - IF_W'(mult_done_i);

    push_pkt          = '0;
    push_pkt.result   = mult_product_i;
    push_pkt.rob_idx  = mult_rob_idx_i;
    push_pkt.dest_tag = mult_dest_tag_i;

    // A done is squashed while older flushes still own pipeline slots; a done
    // in the flush cycle itself is dropped as well.
    discard = mult_done_i & (squash != '0);
    push    = mult_done_i & (squash == '0) & ~flush_i;
    pop     = cdb_req_o & cdb_gnt_i;

    // Credit counts ops still in the multiplier as already occupying a slot,
    // and uses registered state only so it never loops through issue logic.
    issue_ready_o = (int'(count_o) + int'(inflight)) < DEPTH;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      inflight <= '0;
      squash   <= '0;
    end else begin
      // The pipeline keeps draining across a flush, so inflight never resets.
      inflight <= inflight_next;
      if (flush_i) begin
        // Everything still inside the multiplier after this edge is stale.
        squash <= inflight_next;
      end else if (discard) begin
        squash <= squash - IF_W'(1);
      end
    end
  end

  cdb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .clear     (flush_i),
    .push      (push),
    .push_data (push_pkt),
    .pop       (pop),
    .head_data (head_pkt),
    .count     (count_o),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign cdb_req_o      = ~fifo_empty;
  assign cdb_result_o   = head_pkt.result;
  assign cdb_rob_idx_o  = head_pkt.rob_idx;
  assign cdb_dest_tag_o = head_pkt.dest_tag;

  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    !(push && fifo_full && !pop));
  a_start_credit: assert property (@(posedge clock) disable iff (reset)
    !(mult_start_i && !issue_ready_o));
  a_done_has_op: assert property (@(posedge clock) disable iff (reset)
    !(mult_done_i && inflight == '0));

endmodule

// File: tb/tb_mult_cdb_buffer.sv
// Self-checking bench for mult_cdb_buffer. A small multiplier model turns
// each start into a done LAT cycles later; a queue-based model of the buffer
// predicts the outputs, which are compared on every falling edge.
module tb_mult_cdb_buffer;
  import cpu_pkg::*;

  localparam int DEPTH = 4;
  localparam int LAT   = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        start;
  logic        done;
  logic [63:0] product;
  logic [4:0]  rob;
  logic [5:0]  tag;
  logic        gnt;
  logic        issue_ready;
  logic        cdb_req;
  logic [63:0] cdb_result;
  logic [4:0]  cdb_rob;
  logic [5:0]  cdb_tag;
  logic [2:0]  count;

  always #5 clock = ~clock;

  mult_cdb_buffer #(
    .DEPTH(DEPTH), .LAT(LAT), .ROB_IDX_W(5), .PRF_IDX_W(6)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .flush_i        (flush),
    .mult_start_i   (start),
    .mult_done_i    (done),
    .mult_product_i (product),
    .mult_rob_idx_i (rob),
    .mult_dest_tag_i(tag),
    .issue_ready_o  (issue_ready),
    .cdb_req_o      (cdb_req),
    .cdb_gnt_i      (gnt),
    .cdb_result_o   (cdb_result),
    .cdb_rob_idx_o  (cdb_rob),
    .cdb_dest_tag_o (cdb_tag),
    .count_o        (count)
  );

  // Reference model state
  cdb_pkt_t mq[$];
  int       m_inflight;
  int       m_squash;
  cdb_pkt_t pipe_pkt[LAT];
  bit       pipe_v[LAT];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    cdb_pkt_t h;
    h = (mq.size() != 0) ? mq[0] : '0;
    check("cdb_req",     64'(cdb_req),     64'(mq.size() != 0));
    check("count",       64'(count),       64'(mq.size()));
    check("issue_ready", 64'(issue_ready), 64'((mq.size() + m_inflight) < DEPTH));
    check("cdb_result",  cdb_result,       h.result);
    check("cdb_rob_idx", 64'(cdb_rob),     64'(h.rob_idx));
    check("cdb_tag",     64'(cdb_tag),     64'(h.dest_tag));
  endtask

  // One clock cycle: drive at the falling edge, update model at the rising
  // edge, compare at the next falling edge.
  task automatic step(input bit st, input logic [63:0] p, input logic [4:0] r,
                      input logic [5:0] t, input bit g, input bit fl, input bit rst);
    bit       d;
    cdb_pkt_t dp;
    if (st && !rst) check("start_needs_credit", 64'(issue_ready), 64'd1);
    d  = pipe_v[LAT-1];
    dp = d ? pipe_pkt[LAT-1] : '0;
    reset   = rst;
    flush   = fl;
    start   = st;
    gnt     = g;
    done    = d;
    product = dp.result;
    rob     = dp.rob_idx;
    tag     = dp.dest_tag;
    @(posedge clock);
    if (rst) begin
      mq.delete();
      m_inflight = 0;
      m_squash   = 0;
      for (int i = 0; i < LAT; i++) pipe_v[i] = 1'b0;
    end else begin
      if (fl) begin
        mq.delete();
        m_squash = m_inflight + int'(st) - int'(d);
      end else begin
        if (g && mq.size() != 0) void'(mq.pop_front());
        if (d) begin
          if (m_squash == 0) mq.push_back(dp);
          else m_squash--;
        end
      end
      m_inflight = m_inflight + int'(st) - int'(d);
      for (int i = LAT - 1; i > 0; i--) begin
        pipe_v[i]   = pipe_v[i-1];
        pipe_pkt[i] = pipe_pkt[i-1];
      end
      pipe_v[0]   = st;
      pipe_pkt[0] = '{result: p, rob_idx: r, dest_tag: t};
    end
    @(negedge clock);
    compare_all();
  endtask

  task automatic idle(input bit g);
    step(1'b0, 64'd0, 5'd0, 6'd0, g, 1'b0, 1'b0);
  endtask

  task automatic op(input logic [63:0] p, input logic [4:0] r, input logic [5:0] t);
    step(1'b1, p, r, t, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; start = 1'b0; done = 1'b0;
    product = '0; rob = '0; tag = '0; gnt = 1'b0;
    m_inflight = 0; m_squash = 0;
    for (int i = 0; i < LAT; i++) begin
      pipe_v[i] = 1'b0; pipe_pkt[i] = '0;
    end
    @(negedge clock);

    // Reset state
    step(1'b0, 64'd0, 5'd0, 6'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 64'd0, 5'd0, 6'd0, 1'b0, 1'b0, 1'b1);
    check("rst_req",    64'(cdb_req), 64'd0);
    check("rst_count",  64'(count), 64'd0);
    check("rst_ready",  64'(issue_ready), 64'd1);
    check("rst_result", cdb_result, 64'd0);

    // Single op: start at cycle 0, done at cycle 4, visible at cycle 5
    op(64'h2A, 5'd3, 6'd9);
    for (int i = 0; i < 4; i++) idle(1'b0);
    check("single_req",    64'(cdb_req), 64'd1);
    check("single_result", cdb_result, 64'h2A);
    check("single_rob",    64'(cdb_rob), 64'd3);
    check("single_tag",    64'(cdb_tag), 64'd9);
    idle(1'b1);
    check("single_pop_count", 64'(count), 64'd0);
    check("single_pop_req",   64'(cdb_req), 64'd0);

    // Credit: four back-to-back starts with no grant
    for (int i = 0; i < 4; i++) op(64'h1000 + 64'(i), 5'(4 + i), 6'(10 + i));
    check("credit_exhausted", 64'(issue_ready), 64'd0);
    for (int i = 0; i < 4; i++) idle(1'b0);
    check("credit_full_count", 64'(count), 64'd4);
    check("credit_full_ready", 64'(issue_ready), 64'd0);
    check("credit_head",       cdb_result, 64'h1000);
    idle(1'b1);
    check("credit_returned",   64'(issue_ready), 64'd1);
    check("credit_next_head",  cdb_result, 64'h1001);

    // Push and pop together at the highest occupancy credit allows
    op(64'h2000, 5'd8, 6'd20);
    for (int i = 0; i < 3; i++) idle(1'b0);
    idle(1'b1);
    check("pushpop_count", 64'(count), 64'd3);
    check("pushpop_head",  cdb_result, 64'h1002);
    for (int i = 0; i < 3; i++) idle(1'b1);
    check("drain_empty",   64'(count), 64'd0);

    // Stalled grant on a ZERO_REG destination
    op(64'hDEAD_BEEF_0000_0001, 5'd17, ZERO_REG);
    for (int i = 0; i < 4; i++) idle(1'b0);
    for (int i = 0; i < 5; i++) begin
      idle(1'b0);
      check("stall_req",    64'(cdb_req), 64'd1);
      check("stall_result", cdb_result, 64'hDEAD_BEEF_0000_0001);
      check("stall_rob",    64'(cdb_rob), 64'd17);
      check("stall_tag",    64'(cdb_tag), 64'(ZERO_REG));
    end
    idle(1'b1);
    check("stall_broadcast_done", 64'(count), 64'd0);

    // Flush with three in flight plus a start in the flush cycle
    for (int i = 0; i < 3; i++) op(64'h3000 + 64'(i), 5'(i), 6'(30 + i));
    step(1'b1, 64'h3003, 5'd3, 6'd33, 1'b0, 1'b1, 1'b0);
    check("flush_model_squash", 64'(m_squash), 64'd4);
    check("flush_count",        64'(count), 64'd0);
    for (int i = 0; i < 4; i++) idle(1'b0);
    check("flush_dropped", 64'(count), 64'd0);
    op(64'h55, 5'd1, 6'd2);
    for (int i = 0; i < 4; i++) idle(1'b0);
    check("post_flush_req",    64'(cdb_req), 64'd1);
    check("post_flush_result", cdb_result, 64'h55);
    idle(1'b1);

    // Flush with two queued, a done and a grant in the flush cycle
    for (int i = 0; i < 3; i++) op(64'h6000 + 64'(i), 5'(20 + i), 6'(40 + i));
    for (int i = 0; i < 3; i++) idle(1'b0);
    check("flush2_queued", 64'(count), 64'd2);
    step(1'b0, 64'd0, 5'd0, 6'd0, 1'b1, 1'b1, 1'b0);
    check("flush2_count", 64'(count), 64'd0);
    check("flush2_req",   64'(cdb_req), 64'd0);
    for (int i = 0; i < 2; i++) idle(1'b0);

    // Reset mid-operation clears in-flight work
    op(64'h7000, 5'd5, 6'd5);
    idle(1'b0);
    step(1'b0, 64'd0, 5'd0, 6'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) idle(1'b0);
    check("midrst_count", 64'(count), 64'd0);
    check("midrst_ready", 64'(issue_ready), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
